data_memory_mmio: RTL and testbench

- Parametrised successor data memory for the RV32I core on iCE40UP5K.
- Byte-addressed load/store unit backed by SPRAM banks, with:
  - byte/halfword/word stores via SPRAM nibble masks;
  - sign/zero-extended loads;
  - valid/ready request handshake;
  - a memory-mapped LED/GPIO output register.
- Sits between the core's MEM stage and the SPRAM tiles.

---
 rtl/data_memory_pkg.sv | 43 ++++
 rtl/data_memory_mmio_if.sv | 23 ++
 rtl/spram_bank.sv | 46 ++++
 rtl/spram_tile.sv | 37 +++
 rtl/data_memory_mmio.sv | 122 ++++++++++++
 tb/tb_data_memory_mmio.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings and lane helpers for the byte-addressed data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  localparam int unsigned BANK_WORDS_W = 14;
  localparam int unsigned BANK_BYTES   = 65536;

  function automatic logic [3:0] byte_enable(input size_e size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied into every lane it could land in.
  function automatic logic [31:0] replicate(input size_e size, input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input size_e size, input logic zext);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_B:  return zext ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  return zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_mmio_if.sv
// Request/response bus between the MEM stage and the data memory.
interface data_memory_mmio_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/spram_bank.sv
// 16K x 32 bank built from two 16-bit tiles; byte enables become nibble masks.
module spram_bank
  import data_memory_pkg::*;
(
  input  logic                    clk,
  input  logic                    cs,
  input  logic                    we,
  input  logic [3:0]              be,
  input  logic [BANK_WORDS_W-1:0] addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [3:0] mask_lo;
  logic [3:0] mask_hi;

  assign mask_lo = {be[1], be[1], be[0], be[0]};
  assign mask_hi = {be[3], be[3], be[2], be[2]};

  spram_tile u_lo (
    .clk       (clk),
    .addr      (addr),
    .din       (wdata[15:0]),
    .maskwren  (mask_lo),
    .wren      (we),
    .chipselect(cs),
    .standby   (1'b0),
    .sleep     (1'b0),
    .poweroff  (1'b1),
    .dout      (rdata[15:0])
  );

  spram_tile u_hi (
    .clk       (clk),
    .addr      (addr),
    .din       (wdata[31:16]),
    .maskwren  (mask_hi),
    .wren      (we),
    .chipselect(cs),
    .standby   (1'b0),
    .sleep     (1'b0),
    .poweroff  (1'b1),
    .dout      (rdata[31:16])
  );

endmodule

// File: rtl/spram_tile.sv
// Behavioural 16K x 16 single-port RAM tile with nibble write masks and power pins.
module spram_tile
  import data_memory_pkg::*;
(
  input  logic                    clk,
  input  logic [BANK_WORDS_W-1:0] addr,
  input  logic [15:0]             din,
  input  logic [3:0]              maskwren,
  input  logic                    wren,
  input  logic                    chipselect,
  input  logic                    standby,
  input  logic                    sleep,
  input  logic                    poweroff,
  output logic [15:0]             dout
);

  localparam int unsigned DEPTH = 1 << BANK_WORDS_W;

  logic [15:0] mem [DEPTH];
  logic        active;

  // poweroff is active-low: 1 keeps the array powered
  assign active = chipselect && poweroff && !standby && !sleep;

  always_ff @(posedge clk) begin
    if (active && wren) begin
      for (int n = 0; n < 4; n++) begin
        if (maskwren[n]) mem[addr][4*n +: 4] <= din[4*n +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (active && !wren) dout <= mem[addr];
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Byte-addressed load/store unit over SPRAM banks with one memory-mapped GPIO register.
module data_memory_mmio
  import data_memory_pkg::*;
#(
  parameter int unsigned           NUM_BANKS  = 2,
  parameter logic [31:0]           MMIO_ADDR  = 32'h0000_2000,
  parameter int unsigned           GPIO_WIDTH = 8,
  parameter logic [GPIO_WIDTH-1:0] GPIO_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  data_memory_mmio_if.slave     bus,
  output logic [GPIO_WIDTH-1:0] gpio
);

  localparam logic [32:0] MEM_LIMIT = 33'(NUM_BANKS) * 33'(BANK_BYTES);

  size_e       size;
  logic [1:0]  off;
  logic        is_mmio;
  logic        in_range;
  logic        aligned;
  logic        legal;
  logic        accept;
  logic        mem_cs;
  logic        bank_sel;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] bank_rdata [NUM_BANKS];
  logic [31:0] bank_word;
  logic [31:0] src_word;

  logic                  rsp_valid_q;
  logic                  rsp_error_q;
  logic                  load_q;
  logic                  mmio_q;
  logic [1:0]            off_q;
  size_e                 size_q;
  logic                  zext_q;
  logic                  bank_q;
  logic [GPIO_WIDTH-1:0] gpio_q;
  logic [GPIO_WIDTH-1:0] gpio_next;

  assign size      = size_e'(bus.req_size);
  assign off       = bus.req_addr[1:0];
  assign is_mmio   = bus.req_addr == MMIO_ADDR;
  assign in_range  = {1'b0, bus.req_addr} < MEM_LIMIT;
  assign be        = byte_enable(size, off);
  assign wdata_rep = replicate(size, bus.req_wdata);
  assign bank_sel  = (NUM_BANKS > 1) ? bus.req_addr[16] : 1'b0;

  always_comb begin
    case (size)
      SIZE_B:  aligned = 1'b1;
      SIZE_H:  aligned = !off[0];
      SIZE_W:  aligned = off == 2'b00;
      default: aligned = 1'b0;
    endcase
  end

  // The MMIO word shadows the SPRAM word at the same address.
  assign legal         = aligned && (is_mmio || in_range);
  assign bus.req_ready = !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign mem_cs        = accept && legal && !is_mmio;

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    spram_bank u_bank (
      .clk  (clk),
      .cs   (mem_cs && (bank_sel == 1'(b))),
      .we   (bus.req_write),
      .be   (be),
      .addr (bus.req_addr[15:2]),
      .wdata(wdata_rep),
      .rdata(bank_rdata[b])
    );
  end

  always_comb begin
    gpio_next = gpio_q;
    for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
      if (be[i/8]) gpio_next[i] = wdata_rep[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      load_q      <= 1'b0;
      mmio_q      <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SIZE_B;
      zext_q      <= 1'b0;
      bank_q      <= 1'b0;
      gpio_q      <= GPIO_RESET;
    end else begin
      rsp_valid_q <= accept;
      rsp_error_q <= accept && !legal;
      load_q      <= accept && legal && !bus.req_write;
      mmio_q      <= is_mmio;
      off_q       <= off;
      size_q      <= size;
      zext_q      <= bus.req_unsigned;
      bank_q      <= bank_sel;
      if (accept && legal && bus.req_write && is_mmio) gpio_q <= gpio_next;
    end
  end

  // Load data comes straight off the SPRAM output register the cycle after the read.
  always_comb begin
    bank_word = bank_rdata[0];
    if (bank_q) bank_word = bank_rdata[NUM_BANKS-1];
  end

  assign src_word      = mmio_q ? 32'(gpio_q) : bank_word;
  assign bus.rsp_rdata = load_q ? load_extend(src_word, off_q, size_q, zext_q) : 32'h0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign gpio          = gpio_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed and random load/store traffic against a byte-level reference model.
module tb_data_memory_mmio;

  localparam logic [31:0] MMIO = 32'h0000_2000;

  logic       clk;
  logic       rst;
  logic [7:0] gpio;

  data_memory_mmio_if bus ();

  data_memory_mmio #(
    .NUM_BANKS (2),
    .MMIO_ADDR (MMIO),
    .GPIO_WIDTH(8),
    .GPIO_RESET(8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .gpio(gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors;
  int unsigned checks;

  logic [7:0] mem_m [int unsigned];
  logic [7:0] gpio_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic exp_error(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && a[0]) return 1'b1;
    if (s == 2'd2 && a[1:0] != 2'b00) return 1'b1;
    if (a != MMIO && a >= 32'h0002_0000) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-granular view: a store writes 2**size bytes from a upward, a load gathers them.
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int unsigned n;
    logic [7:0]  b;
    rd = 32'h0;
    er = exp_error(a, s);
    if (er) return;
    n = 1 << s;
    for (int k = 0; k < int'(n); k++) begin
      if (w) begin
        if (a == MMIO) begin
          if (k == 0) gpio_m = wd[7:0];
        end else begin
          mem_m[a + 32'(k)] = wd[8*k +: 8];
        end
      end else begin
        if (a == MMIO) b = (k == 0) ? gpio_m : 8'h00;
        else           b = mem_m[a + 32'(k)];
        rd[8*k +: 8] = b;
      end
    end
    if (!w && !u && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
  endtask

  task automatic req(input string tag, input logic w, input logic [31:0] a,
                     input logic [1:0] s, input logic u, input logic [31:0] wd);
    logic [31:0] erd;
    logic        eer;
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_addr     = a;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model(w, a, s, u, wd, erd, eer);
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".error"}, 32'(bus.rsp_error), 32'(eer));
    check({tag, ".rdata"}, bus.rsp_rdata, erd);
    check({tag, ".gpio"}, 32'(gpio), 32'(gpio_m));
  endtask

  task automatic sw(input string t, input logic [31:0] a, input logic [31:0] d);
    req(t, 1'b1, a, 2'd2, 1'b0, d);
  endtask

  task automatic ld(input string t, input logic [31:0] a, input logic [1:0] s, input logic u);
    req(t, 1'b0, a, s, u, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int unsigned pick;
    errors = 0;
    checks = 0;
    gpio_m = 8'h00;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(bus.req_ready), 32'd0);
    check("rst.valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rdata", bus.rsp_rdata, 32'd0);
    check("rst.error", 32'(bus.rsp_error), 32'd0);
    check("rst.gpio", 32'(gpio), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) sw($sformatf("pre0_%0d", i), 32'(4*i), $urandom);
    for (int i = 0; i < 4; i++) sw($sformatf("pre1_%0d", i), 32'h10000 + 32'(4*i), $urandom);
    sw("pre08", 32'h8, 32'h1122_3344);
    sw("pre10", 32'h10, 32'hCAFE_1234);

    sw("sw04", 32'h4, 32'hDEAD_BEEF);
    ld("lw04", 32'h4, 2'd2, 1'b0);

    req("sb09", 1'b1, 32'h9, 2'd0, 1'b0, 32'h0000_0080);
    ld("lb09", 32'h9, 2'd0, 1'b0);
    ld("lbu09", 32'h9, 2'd0, 1'b1);
    ld("lw08", 32'h8, 2'd2, 1'b0);

    req("sh12", 1'b1, 32'h12, 2'd1, 1'b0, 32'h0000_BEEF);
    ld("lh12", 32'h12, 2'd1, 1'b0);
    ld("lw10", 32'h10, 2'd2, 1'b0);
    ld("lhu10", 32'h10, 2'd1, 1'b1);

    req("sb2001", 1'b1, 32'h2001, 2'd0, 1'b0, 32'h11);
    req("sh2002", 1'b1, 32'h2002, 2'd1, 1'b0, 32'h3322);
    sw("swmmio", MMIO, 32'h0000_00A5);
    ld("lwmmio", MMIO, 2'd2, 1'b0);
    ld("lbmmio", MMIO, 2'd0, 1'b0);
    ld("lbu2001", 32'h2001, 2'd0, 1'b1);
    ld("lhu2002", 32'h2002, 2'd1, 1'b1);

    ld("mis_lw06", 32'h6, 2'd2, 1'b0);
    ld("sz3_ld", 32'h4, 2'd3, 1'b0);
    ld("oor_lw", 32'h20000, 2'd2, 1'b0);
    sw("oor_sw", 32'h20000, 32'hFFFF_FFFF);
    sw("mis_sw06", 32'h6, 32'hFFFF_FFFF);
    req("sz3_sw", 1'b1, 32'h0, 2'd3, 1'b0, 32'hFFFF_FFFF);
    req("mis_shmmio", 1'b1, MMIO + 32'h1, 2'd1, 1'b0, 32'hFFFF);
    ld("chk_lw00", 32'h0, 2'd2, 1'b0);
    ld("chk_lw04", 32'h4, 2'd2, 1'b0);

    sw("b2b_sw", 32'h10000, 32'h1234_5678);
    ld("b2b_lw", 32'h10000, 2'd2, 1'b0);
    ld("b2b_bank0", 32'h0, 2'd2, 1'b0);
    req("b2b_sb", 1'b1, 32'h10007, 2'd0, 1'b0, 32'h9C);
    ld("b2b_lw04", 32'h10004, 2'd2, 1'b0);

    @(posedge clk);
    #1;
    check("idle.valid", 32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 16);
      if (pick < 8)       a = 32'(4*pick) + 32'($urandom_range(0, 3));
      else if (pick < 12) a = 32'h10000 + 32'(4*(pick-8)) + 32'($urandom_range(0, 3));
      else if (pick < 14) a = MMIO;
      else if (pick < 15) a = 32'h20000 + 32'($urandom_range(0, 7));
      else if (pick < 16) a = 32'h0001_FFFC + 32'($urandom_range(4, 15));
      else                a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom);
    end

    sw("pre_rst_mmio", MMIO, 32'h0000_005A);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h4;
    bus.req_size  = 2'd2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    gpio_m = 8'h00;
    #1;
    check("mid_rst.valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst.rdata", bus.rsp_rdata, 32'd0);
    check("mid_rst.gpio", 32'(gpio), 32'd0);
    check("mid_rst.ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst.hold", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    ld("post_rst_mmio", MMIO, 2'd2, 1'b0);
    ld("post_rst_lw10000", 32'h10000, 2'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
